compute_in_memory: RTL and testbench
====================================

Name: compute_in_memory

Overview:
- Synaptic-current accumulator for the Izhikevich graph accelerator; sits between the spike FIFO and the neuron update datapath.
- Pops fired-neuron tags from the spike FIFO and adds that neuron's outgoing weight row into every target's next-step current, all targets in parallel.
- Double-buffered: the neuron datapath reads the current-step bank via i_tag/i_out while the next-step bank accumulates; swap exchanges them at the timestep boundary.

Parameters:
- TAG_W, 1, neuron tag width; N = 2**TAG_W neurons.
- W_W, 16, signed weight width.
- I_W, 17, signed current width.
- WEIGHTS, {16'sd0,16'sd250,-16'sd40,16'sd100}, packed N*N*W_W constant; W[src][dst] = WEIGHTS[(src*N+dst)*W_W +: W_W]; default W00=100, W01=-40, W10=250, W11=0.

Ports:
- clk  in  1  rising-edge clock.
- asyn_reset  in  1  asynchronous, active-high reset.
- swap  in  1  timestep-boundary pulse; exchanges banks.
- fifo_empty  in  1  spike FIFO empty flag; first-word-fall-through.
- busy  out  1  high while state!=IDLE or a swap is pending.
- req_deq  out  1  FIFO pop strobe; FIFO pops on the rising edge where it is high.
- fired_tag  in  TAG_W  FIFO head: tag of the fired source neuron; valid while fifo_empty=0.
- i_tag  in  TAG_W  neuron select for the read port.
- i_out  out  I_W  i_cur[i_tag], combinational, signed.
- state_out  out  2  FSM state encoding.

Behaviour:
- Storage: i_cur[N], i_next[N] (I_W signed); swap_pend flag.
- Reset (async): state=IDLE, all i_cur/i_next=0, swap_pend=0; busy=0, req_deq=0, state_out=0, i_out=0.
- States: IDLE=0, FETCH=1, ACCUM=2, SWAP=3; state_out=state.
- IDLE:
  - if swap|swap_pend -> SWAP;
  - else if !fifo_empty -> FETCH;
  - else stay.
  - Swap has priority over pending spikes.
- FETCH:
  - req_deq=1 (Moore, only in this state).
  - Latch src=fired_tag at the edge; FIFO pops on the same edge.
  - -> ACCUM.
- ACCUM, for every dst in parallel: i_next[dst] <= sat(i_next[dst] + sext(W[src][dst])).
  - Then: swap_pend ? IDLE : (!fifo_empty ? FETCH : IDLE).
  - Back-to-back spikes cost 2 cycles each.
- SWAP (1 cycle): i_cur <= i_next; i_next <= 0; swap_pend <= 0; -> IDLE.
- swap sampled high in FETCH/ACCUM sets swap_pend. The in-flight spike completes first, then the swap is taken. swap high while in SWAP is ignored.
- Saturation: sum computed at I_W+1 bits, clamped to [-2**(I_W-1), 2**(I_W-1)-1] = [-65536, 65535].
- busy = (state!=IDLE) | swap_pend; combinational from registers.
- i_out tracks i_tag in the same cycle; unchanged except at the SWAP edge.
- FIFO never popped when fifo_empty=1 at the IDLE/ACCUM decision edge.
- Reset mid-operation aborts immediately. The latched src is discarded and no partial add is applied.

Test Plan:
- Reset, fifo_empty=1, 3 cycles -> state_out=0, busy=0, req_deq=0, i_out=0 for both i_tag values.
- One spike, fired_tag=0, then fifo_empty=1:
  - state sequence 0->1->2->0; req_deq high exactly one cycle.
  - i_out stays 0 before swap.
  - After a swap pulse: state 3 one cycle, then i_out=100 (i_tag=0) and -40 (i_tag=1).
- Spikes tag0 then tag1 back-to-back (FIFO non-empty through ACCUM):
  - states 1,2,1,2,0; two req_deq pulses.
  - After swap: i_out=350 (i_tag=0), -40 (i_tag=1).
- Second swap with no new spikes -> i_out=0 for both tags (next bank cleared by the previous swap).
- swap pulsed during ACCUM with FIFO still non-empty:
  - spike completes, busy stays high, state 2->0->3->0;
  - remaining spike fetched only after SWAP.
- 263 spikes of tag1 then swap -> i_out(i_tag=0)=65535 (saturated), i_out(i_tag=1)=0.
- Assert asyn_reset during ACCUM -> all outputs 0 immediately; subsequent swap yields i_out=0.

Source files
------------

// File: rtl/compute_in_memory.sv
// Synaptic-current accumulator with double-buffered current banks.
// Pops fired-neuron tags from a first-word-fall-through spike FIFO and
// adds the source's outgoing weight row into every target's next-step
// current in parallel. A swap pulse exchanges the banks at the timestep
// boundary, waiting for any in-flight spike to finish first.
module compute_in_memory #(
  parameter int TAG_W = 1,
  parameter int W_W   = 16,
  parameter int I_W   = 17,
  parameter logic [(2**TAG_W)*(2**TAG_W)*W_W-1:0] WEIGHTS =
    {16'sd0, 16'sd250, -16'sd40, 16'sd100}
) (
  input  logic                    clk,
  input  logic                    asyn_reset,
  input  logic                    swap,
  input  logic                    fifo_empty,
  output logic                    busy,
  output logic                    req_deq,
  input  logic [TAG_W-1:0]        fired_tag,
  input  logic [TAG_W-1:0]        i_tag,
  output logic signed [I_W-1:0]   i_out,
  output logic [1:0]              state_out
);

  localparam int N = 2**TAG_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ACCUM = 2'd2,
    SWAP  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_swap_pend;
  logic [TAG_W-1:0]       r_src;
  logic signed [I_W-1:0]  r_i_cur  [N];
  logic signed [I_W-1:0]  r_i_next [N];

  // Weight W[src][dst] from the packed constant table.
  function automatic logic signed [W_W-1:0] weight(input logic [TAG_W-1:0] src,
                                                   input int dst);
    return WEIGHTS[(int'(src) * N + dst) * W_W +: W_W];
  endfunction

  // One-bit-wider sum, clamped to the signed I_W-bit range.
  function automatic logic signed [I_W-1:0] sat_add(input logic signed [I_W-1:0] a,
                                                    input logic signed [W_W-1:0] w);
    logic [I_W:0] s;
    s = {a[I_W-1], a} + {{(I_W+1-W_W){w[W_W-1]}}, w};
    if (s[I_W] != s[I_W-1]) begin
      return s[I_W] ? {1'b1, {(I_W-1){1'b0}}} : {1'b0, {(I_W-1){1'b1}}};
    end
    return s[I_W-1:0];
  endfunction

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) r_state <= IDLE;
    else            r_state <= w_next_state;
  end

  // Next-state logic; a pending or arriving swap outranks queued spikes.
  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (swap || r_swap_pend) w_next_state = SWAP;
        else if (!fifo_empty)    w_next_state = FETCH;
      end
      FETCH: w_next_state = ACCUM;
      ACCUM: begin
        if (r_swap_pend || swap) w_next_state = IDLE;
        else if (!fifo_empty)    w_next_state = FETCH;
        else                     w_next_state = IDLE;
      end
      SWAP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    req_deq   = (r_state == FETCH);
    busy      = (r_state != IDLE) || r_swap_pend;
    state_out = r_state;
  end

  // Remember a swap requested while a spike is in flight.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset)                                          r_swap_pend <= 1'b0;
    else if (r_state == SWAP)                                r_swap_pend <= 1'b0;
    else if (swap && (r_state == FETCH || r_state == ACCUM)) r_swap_pend <= 1'b1;
  end

  // Latch the FIFO head on the popping edge.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset)            r_src <= '0;
    else if (r_state == FETCH) r_src <= fired_tag;
  end

  // Bank update: parallel accumulate into next bank, or exchange banks.
  // NOTE: the banks are N small register words, not a RAM macro, so they
  // are cleared by reset like any other flop.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      for (int d = 0; d < N; d++) begin
        r_i_cur[d]  <= '0;
        r_i_next[d] <= '0;
      end
    end else if (r_state == ACCUM) begin
      for (int d = 0; d < N; d++) begin
        r_i_next[d] <= sat_add(r_i_next[d], weight(r_src, d));
      end
    end else if (r_state == SWAP) begin
      for (int d = 0; d < N; d++) begin
        r_i_cur[d]  <= r_i_next[d];
        r_i_next[d] <= '0;
      end
    end
  end

  assign i_out = r_i_cur[i_tag];

endmodule

// File: tb/tb_compute_in_memory.sv
// Self-checking bench for compute_in_memory: directed scenarios plus
// randomized spike bursts scored against a bank-level reference model.
module tb_compute_in_memory;

  logic               clk;
  logic               asyn_reset;
  logic               swap;
  logic               fifo_empty;
  logic               busy;
  logic               req_deq;
  logic [0:0]         fired_tag;
  logic [0:0]         i_tag;
  logic signed [16:0] i_out;
  logic [1:0]         state_out;

  compute_in_memory dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .swap       (swap),
    .fifo_empty (fifo_empty),
    .busy       (busy),
    .req_deq    (req_deq),
    .fired_tag  (fired_tag),
    .i_tag      (i_tag),
    .i_out      (i_out),
    .state_out  (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: weight table and the two banks, as plain integers.
  int w_tab [2][2] = '{'{100, -40}, '{250, 0}};
  int m_cur [2];
  int m_nxt [2];
  int q [$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int clamp(input int v);
    if (v > 65535)  return 65535;
    if (v < -65536) return -65536;
    return v;
  endfunction

  task automatic model_spike(input int tag);
    for (int d = 0; d < 2; d++) m_nxt[d] = clamp(m_nxt[d] + w_tab[tag][d]);
  endtask

  task automatic model_swap();
    for (int d = 0; d < 2; d++) begin
      m_cur[d] = m_nxt[d];
      m_nxt[d] = 0;
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty = (q.size() == 0);
    fired_tag  = (q.size() != 0) ? 1'(q[0]) : 1'b0;
  endtask

  task automatic push(input int tag);
    q.push_back(tag);
    refresh_fifo();
  endtask

  // Advance one clock; the FIFO pops on any edge where req_deq was high.
  task automatic step();
    logic pop;
    int   tmp;
    pop = req_deq;
    @(posedge clk);
    #1;
    if (pop && q.size() != 0) tmp = q.pop_front();
    refresh_fifo();
  endtask

  task automatic check_banks(input string tag);
    for (int t = 0; t < 2; t++) begin
      i_tag = 1'(t);
      #1;
      check($sformatf("%s_iout%0d", tag, t), int'(i_out), m_cur[t]);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy || q.size() != 0 || state_out != 2'd0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic do_swap(input string tag);
    swap = 1'b1;
    step();
    swap = 1'b0;
    check({tag, "_swap_state"}, int'(state_out), 3);
    step();
    check({tag, "_post_swap_state"}, int'(state_out), 0);
    model_swap();
    check_banks(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    asyn_reset = 1'b1;
    swap       = 1'b0;
    i_tag      = 1'b0;
    m_cur      = '{0, 0};
    m_nxt      = '{0, 0};
    refresh_fifo();

    // Reset hold.
    repeat (3) step();
    check("rst_state", int'(state_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_req", int'(req_deq), 0);
    check_banks("rst");
    asyn_reset = 1'b0;
    step();

    // Single spike of tag 0.
    push(0);
    check("s1_idle", int'(state_out), 0);
    step();
    check("s1_fetch", int'(state_out), 1);
    check("s1_req_hi", int'(req_deq), 1);
    step();
    check("s1_accum", int'(state_out), 2);
    check("s1_req_lo", int'(req_deq), 0);
    check("s1_popped", int'(fifo_empty), 1);
    step();
    check("s1_back_idle", int'(state_out), 0);
    check("s1_busy", int'(busy), 0);
    model_spike(0);
    check_banks("s1_preswap");
    do_swap("s1");

    // Back-to-back spikes tag0, tag1.
    push(0);
    push(1);
    begin
      int exp_st [5] = '{1, 2, 1, 2, 0};
      int exp_rq [5] = '{1, 0, 1, 0, 0};
      for (int i = 0; i < 5; i++) begin
        step();
        check($sformatf("b2b_state%0d", i), int'(state_out), exp_st[i]);
        check($sformatf("b2b_req%0d", i), int'(req_deq), exp_rq[i]);
      end
    end
    model_spike(0);
    model_spike(1);
    do_swap("b2b");

    // Second swap with nothing accumulated.
    do_swap("empty");

    // Swap arriving during ACCUM with a spike still queued.
    push(0);
    push(1);
    step();
    check("sp_fetch", int'(state_out), 1);
    step();
    check("sp_accum", int'(state_out), 2);
    swap = 1'b1;
    step();
    swap = 1'b0;
    check("sp_idle_pend", int'(state_out), 0);
    check("sp_busy_pend", int'(busy), 1);
    check("sp_not_popped", int'(fifo_empty), 0);
    step();
    check("sp_swap", int'(state_out), 3);
    check("sp_busy_swap", int'(busy), 1);
    model_spike(0);
    model_swap();
    step();
    check("sp_idle2", int'(state_out), 0);
    check_banks("sp_after_swap");
    step();
    check("sp_fetch2", int'(state_out), 1);
    wait_idle("sp", 20);
    model_spike(1);
    do_swap("sp_second");

    // Positive saturation: 263 spikes of tag 1.
    for (int i = 0; i < 263; i++) begin
      push(1);
      model_spike(1);
    end
    wait_idle("sat", 1000);
    do_swap("sat");

    // Randomized bursts.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 24));
      for (int i = 0; i < n; i++) begin
        int t;
        t = int'($urandom_range(0, 1));
        push(t);
        model_spike(t);
        if ($urandom_range(0, 3) == 0) step();
      end
      wait_idle($sformatf("rnd%0d", r), 200);
      do_swap($sformatf("rnd%0d", r));
    end

    // Reset in the middle of an accumulate.
    push(0);
    push(1);
    step();
    step();
    check("ra_accum", int'(state_out), 2);
    asyn_reset = 1'b1;
    #1;
    check("ra_state", int'(state_out), 0);
    check("ra_busy", int'(busy), 0);
    check("ra_req", int'(req_deq), 0);
    q.delete();
    refresh_fifo();
    m_cur = '{0, 0};
    m_nxt = '{0, 0};
    check_banks("ra");
    step();
    asyn_reset = 1'b0;
    step();
    do_swap("ra");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
